// File: rtl/apb_master_ctrl_if.sv
// Command/response stream plus APB bus bundle for apb_master_ctrl.
// The master modport is the requester's view; slave is the environment driving it.
interface apb_master_ctrl_if;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdWrite;
  logic [15:0] iCmdAddr;
  logic [31:0] iCmdWdata;
  logic        oRspValid;
  logic        iRspReady;
  logic [31:0] oRspRdata;
  logic        oRspErr;
  logic        oPsel;
  logic        oPenable;
  logic        oPwrite;
  logic [15:0] oPaddr;
  logic [31:0] oPwdata;
  logic [31:0] iPrdata;
  logic        iPready;

  modport master (
    input  iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iRspReady, iPrdata, iPready,
    output oCmdReady, oRspValid, oRspRdata, oRspErr, oPsel, oPenable, oPwrite, oPaddr,
           oPwdata
  );

  modport slave (
    output iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iRspReady, iPrdata, iPready,
    input  oCmdReady, oRspValid, oRspRdata, oRspErr, oPsel, oPenable, oPwrite, oPaddr,
           oPwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB requester: one outstanding valid/ready command mapped onto SETUP/ACCESS transfers.
// Optional hung-transfer abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              iClk,
  input  logic              iRsn,
  apb_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e      state;
  logic        pselQ;
  logic        penableQ;
  logic        pwriteQ;
  logic [15:0] paddrQ;
  logic [31:0] pwdataQ;
  logic        rspValidQ;
  logic        rspErrQ;
  logic [31:0] rspRdataQ;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
  logic [7:0] waitCnt;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state     <= StIdle;
      pselQ     <= 1'b0;
      penableQ  <= 1'b0;
      pwriteQ   <= 1'b0;
      paddrQ    <= '0;
      pwdataQ   <= '0;
      rspValidQ <= 1'b0;
      rspErrQ   <= 1'b0;
      rspRdataQ <= '0;
`ifdef APB_TIMEOUT_EN
      waitCnt   <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (bus.iCmdValid) begin
            if (bus.iCmdAddr[1:0] == 2'b00) begin
              pwriteQ <= bus.iCmdWrite;
              paddrQ  <= bus.iCmdAddr;
              pwdataQ <= bus.iCmdWdata;
              pselQ   <= 1'b1;
              state   <= StSetup;
            end else begin
              // Misaligned: answered locally, the bus never sees it.
              rspValidQ <= 1'b1;
              rspErrQ   <= 1'b1;
              rspRdataQ <= '0;
              state     <= StResp;
            end
          end
        end
        StSetup: begin
          penableQ <= 1'b1;
          state    <= StAccess;
`ifdef APB_TIMEOUT_EN
          waitCnt  <= '0;
`endif
        end
        StAccess: begin
          if (bus.iPready) begin
            pselQ     <= 1'b0;
            penableQ  <= 1'b0;
            rspValidQ <= 1'b1;
            rspErrQ   <= 1'b0;
            rspRdataQ <= pwriteQ ? 32'd0 : bus.iPrdata;
            state     <= StResp;
          end
`ifdef APB_TIMEOUT_EN
          else if (waitCnt == TimeoutLast) begin
            pselQ     <= 1'b0;
            penableQ  <= 1'b0;
            rspValidQ <= 1'b1;
            rspErrQ   <= 1'b1;
            rspRdataQ <= '0;
            state     <= StResp;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
`endif
        end
        StResp: begin
          if (bus.iRspReady) begin
            rspValidQ <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.oCmdReady = (state == StIdle);
  assign bus.oPsel     = pselQ;
  assign bus.oPenable  = penableQ;
  assign bus.oPwrite   = pwriteQ;
  assign bus.oPaddr    = paddrQ;
  assign bus.oPwdata   = pwdataQ;
  assign bus.oRspValid = rspValidQ;
  assign bus.oRspErr   = rspErrQ;
  assign bus.oRspRdata = rspRdataQ;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a 16-word completer memory model.
// Timeout expectations follow APB_TIMEOUT_EN with TIMEOUT_CYC=4.
module tb_apb_master_ctrl;

  logic iClk;
  logic iRsn;
  apb_master_ctrl_if bus ();

  apb_master_ctrl #(.TIMEOUT_CYC(4)) dut (
    .iClk(iClk),
    .iRsn(iRsn),
    .bus (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] mem [16];
  logic        memMode;

  logic        got;
  logic [31:0] rdata;
  logic        err;
  int          pselCyc;
  int          penCyc;
  int          lat;
  logic        clean;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Issues one command, plays the completer (waits = ACCESS cycles with PREADY low),
  // then consumes the response after holdCyc cycles of backpressure.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input int waits, input int maxCyc, input int holdCyc, input string tag);
    logic        stable;
    logic [31:0] r0;
    logic        e0;
    check({tag, "_cmdrdy"}, {31'd0, bus.oCmdReady}, 32'd1);
    bus.iCmdValid = 1'b1;
    bus.iCmdWrite = wr;
    bus.iCmdAddr  = addr;
    bus.iCmdWdata = wdata;
    @(posedge iClk); #1;
    bus.iCmdValid = 1'b0;
    got = 1'b0; rdata = '0; err = 1'b0;
    pselCyc = 0; penCyc = 0; lat = 1; stable = 1'b1;
    while (!got && lat <= maxCyc) begin
      bus.iPready = 1'b0;
      if (bus.oPsel) begin
        pselCyc++;
        if (bus.oPaddr !== addr || bus.oPwrite !== wr || bus.oPwdata !== wdata) stable = 1'b0;
      end
      if (bus.oPenable) begin
        penCyc++;
        bus.iPrdata = memMode ? mem[addr[5:2]] : (32'hC0DE_0000 | 32'(penCyc));
        if (penCyc > waits) begin
          bus.iPready = 1'b1;
          if (bus.oPwrite) mem[bus.oPaddr[5:2]] = bus.oPwdata;
        end
      end
      if (bus.oRspValid) begin
        got   = 1'b1;
        rdata = bus.oRspRdata;
        err   = bus.oRspErr;
      end else begin
        @(posedge iClk); #1;
        lat++;
      end
    end
    bus.iPready = 1'b0;
    check({tag, "_bus_stable"}, {31'd0, stable}, 32'd1);
    if (got) begin
      check({tag, "_psel_in_resp"}, {31'd0, bus.oPsel}, 32'd0);
      r0 = rdata; e0 = err; stable = 1'b1;
      for (int i = 0; i < holdCyc; i++) begin
        bus.iRspReady = 1'b0;
        @(posedge iClk); #1;
        if (!bus.oRspValid || bus.oRspRdata !== r0 || bus.oRspErr !== e0 || bus.oCmdReady)
          stable = 1'b0;
      end
      if (holdCyc > 0) check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
      bus.iRspReady = 1'b1;
      check({tag, "_cmdrdy_busy"}, {31'd0, bus.oCmdReady}, 32'd0);
      @(posedge iClk); #1;
      check({tag, "_rsp_done"}, {31'd0, bus.oRspValid}, 32'd0);
      check({tag, "_cmdrdy_after"}, {31'd0, bus.oCmdReady}, 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    memMode       = 1'b1;
    iRsn          = 1'b0;
    bus.iCmdValid = 1'b0;
    bus.iCmdWrite = 1'b0;
    bus.iCmdAddr  = '0;
    bus.iCmdWdata = '0;
    bus.iRspReady = 1'b1;
    bus.iPrdata   = '0;
    bus.iPready   = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_cmdrdy", {31'd0, bus.oCmdReady}, 32'd1);
    check("rst_psel", {31'd0, bus.oPsel}, 32'd0);
    check("rst_penable", {31'd0, bus.oPenable}, 32'd0);
    check("rst_pwrite", {31'd0, bus.oPwrite}, 32'd0);
    check("rst_paddr", {16'd0, bus.oPaddr}, 32'd0);
    check("rst_pwdata", bus.oPwdata, 32'd0);
    check("rst_rspvalid", {31'd0, bus.oRspValid}, 32'd0);
    check("rst_rdata", bus.oRspRdata, 32'd0);
    check("rst_err", {31'd0, bus.oRspErr}, 32'd0);
    iRsn = 1'b1;
    @(posedge iClk); #1;

    // Zero-wait write then read back through the completer memory.
    xfer(1'b1, 16'h8004, 32'h1234_5678, 0, 20, 0, "wr");
    check("wr_got", {31'd0, got}, 32'd1);
    check("wr_psel_cyc", pselCyc, 32'd2);
    check("wr_pen_cyc", penCyc, 32'd1);
    check("wr_lat", lat, 32'd3);
    check("wr_rdata", rdata, 32'd0);
    check("wr_err", {31'd0, err}, 32'd0);

    xfer(1'b0, 16'h8004, 32'h0, 0, 20, 0, "rd");
    check("rd_psel_cyc", pselCyc, 32'd2);
    check("rd_lat", lat, 32'd3);
    check("rd_rdata", rdata, 32'h1234_5678);
    check("rd_err", {31'd0, err}, 32'd0);

    // Three wait states; rdata must be the value presented on the PREADY cycle.
    memMode = 1'b0;
    xfer(1'b0, 16'h803C, 32'h0, 3, 30, 0, "ws");
    check("ws_pen_cyc", penCyc, 32'd4);
    check("ws_psel_cyc", pselCyc, 32'd5);
    check("ws_lat", lat, 32'd6);
    check("ws_rdata", rdata, 32'hC0DE_0004);
    check("ws_err", {31'd0, err}, 32'd0);
    memMode = 1'b1;

    xfer(1'b1, 16'h8002, 32'hDEAD_BEEF, 0, 20, 0, "mis");
    check("mis_got", {31'd0, got}, 32'd1);
    check("mis_psel_cyc", pselCyc, 32'd0);
    check("mis_lat", lat, 32'd1);
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_rdata", rdata, 32'd0);

    xfer(1'b0, 16'h8004, 32'h0, 0, 20, 5, "bp");
    check("bp_rdata", rdata, 32'h1234_5678);

`ifdef APB_TIMEOUT_EN
    memMode = 1'b0;
    xfer(1'b0, 16'h8010, 32'h0, 1000, 40, 0, "to");
    check("to_got", {31'd0, got}, 32'd1);
    check("to_pen_cyc", penCyc, 32'd4);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_rdata", rdata, 32'd0);
    xfer(1'b0, 16'h8010, 32'h0, 1000, 3, 0, "stall");
    memMode = 1'b1;
    check("stall_in_access", {31'd0, bus.oPenable}, 32'd1);
`else
    xfer(1'b0, 16'h8010, 32'h0, 1000, 120, 0, "hang");
    check("hang_no_rsp", {31'd0, got}, 32'd0);
    check("hang_pen_100", {31'd0, penCyc >= 100}, 32'd1);
    check("hang_in_access", {31'd0, bus.oPenable}, 32'd1);
`endif

    // Reset during a wait state discards the transfer.
    iRsn = 1'b0;
    @(posedge iClk); #1;
    check("mrst_psel", {31'd0, bus.oPsel}, 32'd0);
    check("mrst_penable", {31'd0, bus.oPenable}, 32'd0);
    check("mrst_rspvalid", {31'd0, bus.oRspValid}, 32'd0);
    check("mrst_cmdrdy", {31'd0, bus.oCmdReady}, 32'd1);
    iRsn = 1'b1;
    bus.iPready = 1'b1;
    clean = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge iClk); #1;
      if (bus.oRspValid || bus.oPsel) clean = 1'b0;
    end
    bus.iPready = 1'b0;
    check("mrst_quiet", {31'd0, clean}, 32'd1);

    xfer(1'b0, 16'h8004, 32'h0, 1, 20, 0, "post");
    check("post_rdata", rdata, 32'h1234_5678);
    check("post_lat", lat, 32'd4);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns each result on a valid/ready response channel. It sits on the bus-bridge side of the APB segment and drives the APB completers, e.g. the SP-SRAM completer window at 0x8000–0x803C. It handles one outstanding transfer at a time, honours PREADY wait states, rejects misaligned addresses locally and can optionally abort hung transfers.

## Interface
Parameters:
- TIMEOUT_CYC, 16, number of ACCESS cycles allowed with iPready low before abort; legal range 2–255, only used with APB_TIMEOUT_EN.

Ports:
- iClk  in  1  clock, rising edge
- iRsn  in  1  reset, synchronous, active low
- iCmdValid  in  1  command valid
- oCmdReady  out  1  command accepted when high with iCmdValid
- iCmdWrite  in  1  1 = write, 0 = read
- iCmdAddr  in  16  byte address
- iCmdWdata  in  32  write data
- oRspValid  out  1  response valid
- iRspReady  in  1  response consumed when high with oRspValid
- oRspRdata  out  32  read data; 0 for writes and errors
- oRspErr  out  1  1 = misaligned address or timeout
- oPsel  out  1  APB PSEL
- oPenable  out  1  APB PENABLE
- oPwrite  out  1  APB PWRITE
- oPaddr  out  16  APB PADDR
- oPwdata  out  32  APB PWDATA
- iPrdata  in  32  APB PRDATA
- iPready  in  1  APB PREADY

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- oCmdReady = (state == IDLE). It is combinational from state and is 1 right after reset.
- IDLE, accept with aligned address (iCmdAddr[1:0] == 0):
  - latch write, addr and wdata into oPwrite, oPaddr and oPwdata
  - go to SETUP
- IDLE, accept with misaligned address:
  - no APB activity
  - go to RESP with oRspErr=1 and oRspRdata=0
- SETUP: oPsel=1, oPenable=0. Always goes to ACCESS next cycle.
- ACCESS: oPsel=1, oPenable=1.
  - iPready=1: capture iPrdata into oRspRdata (reads only; writes return 0), set oRspErr=0, go to RESP.
  - iPready=0: stay in ACCESS.
- RESP: oPsel=0, oPenable=0, oRspValid=1.
  - iRspReady=1: go to IDLE.
  - iRspReady=0: hold all response outputs stable.
- oPaddr, oPwrite and oPwdata stay stable from SETUP through the end of ACCESS. They keep their last value afterwards and change only on the next accept.
- All outputs except oCmdReady are registered.
- Reset values: oPsel=0, oPenable=0, oPwrite=0, oPaddr=0, oPwdata=0, oRspValid=0, oRspRdata=0, oRspErr=0.
- Reset is synchronous and wins over every state, including mid-ACCESS. On reset, PSEL/PENABLE drop the next edge and any in-flight transfer and response are discarded.

## Timing
- Accept at edge N (aligned address, zero-wait completer):
  - SETUP during cycle N+1
  - ACCESS during N+2; iPready sampled at the end of N+2
  - oRspValid high during N+3
- Each wait state (iPready=0 in ACCESS) extends ACCESS and delays oRspValid by 1 cycle.
- Misaligned command: oRspValid high in cycle N+1.
- Throughput with iRspReady held high: one transfer per 4 cycles, i.e. IDLE→SETUP→ACCESS→RESP→IDLE.
- iCmdValid is ignored outside IDLE. A command cannot be accepted in the same cycle a response is consumed.

## Configuration
- APB_TIMEOUT_EN defined:
  - an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with iPready=0
  - when the counter reaches TIMEOUT_CYC-1 and iPready is still 0, the FSM goes to RESP with oRspErr=1 and oRspRdata=0, and PSEL/PENABLE drop the next cycle
  - iPready=1 in the same cycle as the limit is a normal completion
- APB_TIMEOUT_EN undefined: no counter, and ACCESS waits indefinitely for iPready.

## Test plan
- Write then read, zero-wait: write 0x8004 / 0x1234_5678, then read 0x8004. Required: PSEL high 2 cycles per transfer with PENABLE in the 2nd; read response 0x1234_5678 with err=0; response 3 cycles after each accept.
- Wait states: read 0x803C with iPready low for 3 ACCESS cycles. Required: PENABLE high 4 cycles; oPaddr stable throughout; rdata equals iPrdata sampled at the PREADY cycle.
- Misaligned command: write to 0x8002. Required: oPsel never asserts; oRspValid in the next cycle with err=1 and rdata=0.
- Response backpressure: hold iRspReady low 5 cycles after a read. Required: oRspValid and rdata stable; oCmdReady=0 until the handshake, then 1 in the following cycle.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=4): iPready tied 0. Required: PENABLE high exactly 4 cycles, then response with err=1 and rdata=0. Without the macro: PENABLE stays high for 100+ cycles.
- Reset mid-ACCESS: assert iRsn=0 during a wait state. Required: next edge gives PSEL=0, PENABLE=0, oRspValid=0, oCmdReady=1; no response is produced after release.
